game_dumper: RTL
================

Name: game_dumper

Overview:
- Reads a loaded game image back out of the unified NES memory space and streams it as an iNES byte stream: 16-byte header, then PRG ROM, then CHR ROM.
- It is the reverse of the iNES loader path. It feeds the AXI readback path so software can verify or save the image that was loaded.
- It drives the memory controller read port only while the integrator grants access, i.e. while the NES machine is held in reset.

Parameters:
- PRG_BASE, 22'h00_0000, memory address of PRG ROM byte 0
- CHR_BASE, 22'h20_0000, memory address of CHR ROM byte 0

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a dump when not busy
- prg_banks  in  8  PRG size in 16KB units; latched at start
- chr_banks  in  8  CHR size in 8KB units; latched at start
- flags6  in  8  iNES header byte 6; latched at start
- flags7  in  8  iNES header byte 7; latched at start
- mem_grant  in  1  1 = block may issue memory reads
- mem_read  out  1  one-cycle read strobe to memory controller
- mem_addr  out  22  read address
- mem_din  in  8  read data, valid 2 cycles after mem_read
- out_data  out  8  stream byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts byte when out_valid & out_ready
- busy  out  1  dump in progress
- done  out  1  level; last byte accepted, held until next start or reset

Behaviour:
- Reset values: mem_read=0, mem_addr=0, out_data=0, out_valid=0, busy=0, done=0. State is IDLE.
- States and transitions:
  - IDLE: start=1 latches the inputs, sets busy=1 and done=0, clears the byte counter, goes to HEADER. start while busy is ignored.
  - HEADER: emits 16 bytes, index 0..15: 4E 45 53 1A, prg_banks, chr_banks, flags6, flags7, then eight 00.
    - out_valid rises the cycle after entering HEADER.
    - Each accept presents the next byte the following cycle.
    - The accept of byte 15 moves to PRG, or to CHR if prg_banks==0, or to DONE if both are 0.
  - PRG: bytes_left = {prg_banks,14'b0} (22-bit). Addresses PRG_BASE .. PRG_BASE+bytes_left-1, incrementing.
  - CHR: bytes_left = {1'b0,chr_banks,13'b0}, starting at CHR_BASE.
  - Segment exit: the accept of a segment's last byte goes to CHR, or to DONE if that segment is empty. prg_banks==0 skips PRG; chr_banks==0 skips CHR.
  - DONE: busy=0, done=1, out_valid=0. start restarts the dump exactly as from IDLE.
- Read sequencing (PRG/CHR), at most one read outstanding:
  - Issue a read in cycle T when mem_grant=1, no read is outstanding, bytes remain, and either out_valid=0 or an accept occurs in cycle T.
  - mem_read is high for cycle T only. mem_addr is set in cycle T and held until the next issue.
  - mem_din is sampled at the end of cycle T+2 into out_data. out_valid=1 from T+3.
  - Peak throughput is 1 byte per 3 cycles.
- Backpressure: out_data is stable while out_valid & !out_ready. No read is issued while a byte is waiting unaccepted.
- mem_grant=0 blocks new issues only. An outstanding read still completes and is captured.
- The byte counter decrements on each accept, not on issue. A segment ends only on accept of its last byte.
- Width rules:
  - prg_banks=255 gives 0x3FC000 bytes. The address wraps modulo 2^22 with no error flag; the integrator bounds prg_banks to 64.
  - Address increment is 22-bit.
- Reset mid-operation: an outstanding read is discarded, out_valid drops on the next cycle, and the state returns to IDLE.
- Simultaneous events: start in the same cycle as reset is ignored.

Test Plan:
- prg_banks=1, chr_banks=0, flags6=01, flags7=00, out_ready=1, mem_grant=1, memory[a]=a[7:0]:
  - 16 header bytes 4E 45 53 1A 01 00 01 00 00.. are seen.
  - 16384 data bytes follow with values 00,01,..,FF repeating.
  - Addresses run 0x000000..0x003FFF.
  - done=1 after the last accept. Total 16400 accepts.
- prg_banks=2, chr_banks=1:
  - The last PRG read is at 0x007FFF; the next read is at 0x200000.
  - The last CHR read is at 0x201FFF. Total 40976 bytes.
  - Gap between PRG and CHR reads is 3 cycles.
- Random out_ready (50%):
  - out_data never changes while valid & !ready.
  - mem_read never asserts while a byte is waiting.
  - The stream is identical to the out_ready=1 run.
- mem_grant held low for 20 cycles mid-PRG, one cycle after a mem_read:
  - That byte is still delivered.
  - No further mem_read occurs until mem_grant=1; the stream then resumes at the next address.
- start pulsed during CHR: no effect on the stream and latched sizes are unchanged. start in DONE restarts from header byte 0.
- reset asserted during a PRG read:
  - The cycle after reset deasserts, out_valid=0, busy=0, done=0, mem_read=0.
  - A subsequent start produces a full, correct stream.

Source files
------------

// File: rtl/game_dumper_if.sv
// Memory read port and byte stream of the game image dumper.
// The dumper is the master side; memory controller and consumer are the slave side.
interface game_dumper_if;
    logic        mem_grant;
    logic        mem_read;
    logic [21:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        input  mem_grant, mem_din, out_ready,
        output mem_read, mem_addr, out_data, out_valid
    );

    modport slave (
        output mem_grant, mem_din, out_ready,
        input  mem_read, mem_addr, out_data, out_valid
    );
endinterface

// File: rtl/game_dumper.sv
// Streams a loaded game image back out of NES memory as an iNES byte stream:
// 16-byte header, then PRG ROM, then CHR ROM.
module game_dumper #(
    parameter logic [21:0] PRG_BASE = 22'h00_0000,
    parameter logic [21:0] CHR_BASE = 22'h20_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           prg_banks,
    input  logic [7:0]           chr_banks,
    input  logic [7:0]           flags6,
    input  logic [7:0]           flags7,
    game_dumper_if.master        bus,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PRG,
        CHR,
        FINISHED
    } state_t;

    state_t      state;
    logic [7:0]  prg_q;
    logic [7:0]  chr_q;
    logic [7:0]  f6_q;
    logic [7:0]  f7_q;
    logic [21:0] cnt;
    logic [21:0] iss_left;
    logic [21:0] iss_addr;
    logic        iss_chr;
    logic [21:0] last_addr;
    logic        pend1;
    logic        pend2;
    logic [7:0]  data_q;
    logic        valid_q;

    logic        launch;
    logic        accept;
    logic        in_seg;
    logic        issue;
    logic [21:0] prg_size;
    logic [21:0] chr_size;
    logic [21:0] prg_size_in;
    logic [21:0] chr_size_in;

    assign prg_size    = {prg_q, 14'b0};
    assign chr_size    = {1'b0, chr_q, 13'b0};
    assign prg_size_in = {prg_banks, 14'b0};
    assign chr_size_in = {1'b0, chr_banks, 13'b0};

    assign launch = start && (state == IDLE || state == FINISHED);
    assign accept = valid_q && bus.out_ready;
    assign in_seg = (state == PRG) || (state == CHR);

    // The issue side runs ahead of the accept side, so the first CHR read
    // can go out in the same cycle the last PRG byte is accepted.
    assign issue = in_seg && bus.mem_grant && !pend1 && !pend2 &&
                   (iss_left != 22'd0) && (!valid_q || bus.out_ready);

    assign bus.mem_read  = issue;
    assign bus.mem_addr  = issue ? iss_addr : last_addr;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;

    function automatic logic [7:0] hdr_at(input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = 8'h4E;
            4'd1:    b = 8'h45;
            4'd2:    b = 8'h53;
            4'd3:    b = 8'h1A;
            4'd4:    b = prg_q;
            4'd5:    b = chr_q;
            4'd6:    b = f6_q;
            4'd7:    b = f7_q;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Read issue, read pipeline tracking and the output stream FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prg_q     <= 8'd0;
            chr_q     <= 8'd0;
            f6_q      <= 8'd0;
            f7_q      <= 8'd0;
            cnt       <= 22'd0;
            iss_left  <= 22'd0;
            iss_addr  <= 22'd0;
            iss_chr   <= 1'b0;
            last_addr <= 22'd0;
            pend1     <= 1'b0;
            pend2     <= 1'b0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pend1 <= issue;
            pend2 <= pend1;

            if (issue) begin
                last_addr <= iss_addr;
                if (iss_left == 22'd1 && !iss_chr && chr_q != 8'd0) begin
                    iss_chr  <= 1'b1;
                    iss_addr <= CHR_BASE;
                    iss_left <= chr_size;
                end else begin
                    iss_left <= iss_left - 22'd1;
                    iss_addr <= iss_addr + 22'd1;
                end
            end

            if (launch) begin
                state   <= HEADER;
                prg_q   <= prg_banks;
                chr_q   <= chr_banks;
                f6_q    <= flags6;
                f7_q    <= flags7;
                cnt     <= 22'd0;
                valid_q <= 1'b0;
                pend1   <= 1'b0;
                pend2   <= 1'b0;
                busy    <= 1'b1;
                done    <= 1'b0;
                if (prg_banks != 8'd0) begin
                    iss_chr  <= 1'b0;
                    iss_addr <= PRG_BASE;
                    iss_left <= prg_size_in;
                end else begin
                    iss_chr  <= 1'b1;
                    iss_addr <= CHR_BASE;
                    iss_left <= chr_size_in;
                end
            end else begin
                unique case (state)
                    HEADER: begin
                        if (!valid_q) begin
                            data_q  <= hdr_at(cnt[3:0]);
                            valid_q <= 1'b1;
                        end else if (accept) begin
                            if (cnt[3:0] == 4'd15) begin
                                valid_q <= 1'b0;
                                if (prg_q != 8'd0) begin
                                    state <= PRG;
                                    cnt   <= prg_size;
                                end else if (chr_q != 8'd0) begin
                                    state <= CHR;
                                    cnt   <= chr_size;
                                end else begin
                                    state <= FINISHED;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                cnt    <= cnt + 22'd1;
                                data_q <= hdr_at(cnt[3:0] + 4'd1);
                            end
                        end
                    end
                    PRG, CHR: begin
                        if (accept) begin
                            valid_q <= 1'b0;
                            if (cnt == 22'd1) begin
                                if (state == PRG && chr_q != 8'd0) begin
                                    state <= CHR;
                                    cnt   <= chr_size;
                                end else begin
                                    state <= FINISHED;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt - 22'd1;
                            end
                        end
                        if (pend2) begin
                            data_q  <= bus.mem_din;
                            valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
